cn_msg_expander: RTL and testbench
==================================

# cn_msg_expander

Check-node message expander for the layered min-sum LDPC decoder. It accepts compressed check-node records from the min-sum tree stage: min1, min2, min1 index and the per-edge input signs. It then regenerates the DEG individual check-to-variable messages, emitting one per cycle in edge order, with offset-min-sum correction applied. It sits between the compressed check-node storage and the variable-node update path, and buffers up to two records so the min-sum stage can run ahead.

## Interface
Parameters:
- MAG_W, 5, magnitude width of min1/min2 and of output magnitude
- DEG, 8, check-node degree (edges per record), legal 2..8
- IDX_W, 3, width of min1 index / edge number
- OFFSET, 1, offset-min-sum correction subtracted from every magnitude

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  compressed record present
- in_ready  out  1  record buffer can accept (count < 2)
- in_min1  in  MAG_W  smallest input magnitude
- in_min2  in  MAG_W  second smallest input magnitude
- in_idx  in  IDX_W  edge index holding min1
- in_signs  in  DEG  sign bit of each incoming variable-to-check message, bit e = edge e
- out_valid  out  1  message on out_msg valid
- out_ready  in  1  downstream accepts message
- out_msg  out  MAG_W+1  sign-magnitude message {sign, mag}
- out_edge  out  IDX_W  edge number of out_msg
- out_last  out  1  high on edge DEG-1 of a record
- err_idx  out  1  sticky: a record was accepted with in_idx >= DEG

## Operation
- Record buffer: 2-entry FIFO storing {min1, min2, idx, signs, total_sign}. total_sign is the XOR of in_signs, computed at push.
- Push when in_valid && in_ready. in_ready = (count != 2), driven only from registered count. There is no pass-through when full, even if a pop happens in the same cycle.
- States: IDLE (count == 0, out_valid = 0) and EMIT (count >= 1, out_valid = 1). Edge counter e runs 0..DEG-1 on the head record.
- Per-edge generation from the head record:
  - raw = (e == idx) ? min2 : min1
  - mag = raw - OFFSET, saturating at 0 (no wrap)
  - sign = total_sign ^ signs[e]
  - if mag == 0, sign is forced to 0 (no negative zero)
- out_msg, out_edge and out_last are combinational from the head entry and e. They are held stable while out_valid && !out_ready.
- Handshake fires on out_valid && out_ready:
  - e < DEG-1: increment e.
  - e == DEG-1: pop head, e = 0, out_last asserted for that beat. The next record, if present, is emitted on the next cycle with no bubble.
- Simultaneous push and pop (count 1): count stays 1, and the new record becomes head after the pop.
- Simultaneous push and pop (count 2): impossible, since in_ready = 0.
- in_idx >= DEG: no edge receives min2, all edges use min1. err_idx sets and stays set until reset.
- min2 < min1 on input is not checked; values are used as given.

## Timing
- Reset (rst_n low at a clock edge) sets count = 0, e = 0 and err_idx = 0. Consequently out_valid = 0, out_last = 0, out_msg = 0, out_edge = 0, and in_ready = 1. Outputs are zeroed whenever count == 0.
- in_valid is ignored in any cycle where rst_n is low.
- Reset mid-record discards both buffered entries and the partial edge count. No further beats of that record are emitted.
- Latency: a record accepted at edge N gives out_valid = 1 with edge 0 in the cycle after N.
- Throughput: one message per cycle. Sustained full rate needs one record every DEG cycles. The 2-deep buffer absorbs one record of jitter.
- A record occupies exactly DEG accepted beats. out_valid never drops mid-record.

## Test plan
- Basic expand (OFFSET=1): min1=2, min2=5, idx=3, signs=8'b00000101, so total_sign=0. Required output for edges 0..7: 6'b100001, 000001, 100001, 000100, 000001, 000001, 000001, 000001. out_last is high on edge 7 only, and the first beat appears 1 cycle after acceptance.
- Zero saturation and sign clamp: use the min-sum output for inputs 1,12,0,4,2,13,10,0, i.e. min1=0, min2=0, idx=2, with signs=8'b11111111. All 8 messages must be 6'b000000, with no negative zero and no wrap.
- Backpressure: hold out_ready=0 for 4 cycles at edge 2. out_msg and out_edge must stay constant. Then push 2 more records. in_ready must go to 0 after count reaches 2, and the third in_valid must wait until the first record's edge-7 pop.
- Back-to-back: stream 3 records with out_ready=1. The output must show 24 consecutive valid beats with out_edge cycling 0..7, no bubbles, and out_last on beats 7, 15 and 23.
- Bad index: idx=7 with DEG=6, min1=3, min2=6. All 6 edges must carry magnitude 2, err_idx must rise and stay set, and it must clear only on rst_n.
- Reset mid-record: assert rst_n=0 at edge 4 with 2 records buffered. The next cycle must show out_valid=0, in_ready=1 and err_idx=0, and no stale beats may follow.

Source files
------------

// File: rtl/cn_msg_expander.sv
// Check-node message expander: turns compressed min-sum records into DEG
// offset-corrected sign-magnitude messages, one per accepted beat, in edge order.
module cn_msg_expander #(
    parameter int MAG_W  = 5,
    parameter int DEG    = 8,
    parameter int IDX_W  = 3,
    parameter int OFFSET = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MAG_W-1:0] in_min1,
    input  logic [MAG_W-1:0] in_min2,
    input  logic [IDX_W-1:0] in_idx,
    input  logic [DEG-1:0]   in_signs,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MAG_W:0]   out_msg,
    output logic [IDX_W-1:0] out_edge,
    output logic             out_last,
    output logic             err_idx,
    output logic             dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid never waits on ready, and payload is held while valid && !ready.

    typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

    state_t           state;
    logic [MAG_W-1:0] min1_q  [2];
    logic [MAG_W-1:0] min2_q  [2];
    logic [IDX_W-1:0] idx_q   [2];
    logic [DEG-1:0]   signs_q [2];
    logic             tsign_q [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       count;
    logic [1:0]       count_nxt;
    logic [IDX_W-1:0] e;

    logic             push;
    logic             fire;
    logic             edge_last;
    logic             pop;
    logic [MAG_W-1:0] raw;
    logic [MAG_W-1:0] mag;
    logic             sign;

    // in_ready depends only on the registered count: no pass-through when full.
    assign in_ready  = (count != 2'd2);
    assign push      = in_valid && in_ready;
    assign out_valid = (state == EMIT);
    assign fire      = out_valid && out_ready;
    assign edge_last = (e == IDX_W'(DEG - 1));
    assign pop       = fire && edge_last;
    assign dbg_state = (state == EMIT);

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 2'd1;
            2'b01:   count_nxt = count - 2'd1;
            default: count_nxt = count;
        endcase
    end

    // An out-of-range idx never matches e, so every edge falls back to min1.
    always_comb begin
        raw      = (e == idx_q[rd_ptr]) ? min2_q[rd_ptr] : min1_q[rd_ptr];
        mag      = (raw > MAG_W'(OFFSET)) ? raw - MAG_W'(OFFSET) : '0;
        sign     = (mag != '0) && (tsign_q[rd_ptr] ^ signs_q[rd_ptr][e]);
        out_msg  = '0;
        out_edge = '0;
        out_last = 1'b0;
        if (out_valid) begin
            out_msg  = {sign, mag};
            out_edge = e;
            out_last = edge_last;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            count   <= 2'd0;
            e       <= '0;
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            err_idx <= 1'b0;
        end else begin
            if (push) begin
                min1_q[wr_ptr]  <= in_min1;
                min2_q[wr_ptr]  <= in_min2;
                idx_q[wr_ptr]   <= in_idx;
                signs_q[wr_ptr] <= in_signs;
                tsign_q[wr_ptr] <= ^in_signs;
                wr_ptr          <= ~wr_ptr;
                if (int'(in_idx) >= DEG)
                    err_idx <= 1'b1;
            end
            if (fire)
                e <= edge_last ? '0 : e + 1'b1;
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count_nxt;
            state <= (count_nxt != 2'd0) ? EMIT : IDLE;
        end
    end

endmodule

// File: tb/tb_cn_msg_expander.sv
// Bench for cn_msg_expander: directed plan cases plus randomized records,
// scored against a queue of expected {last, edge, msg} beats.
module tb_cn_msg_expander;

    localparam int MAG_W  = 5;
    localparam int IDX_W  = 3;
    localparam int OFFSET = 1;
    localparam int W      = 1 + IDX_W + MAG_W + 1;

    logic clk = 0;
    logic rst_n = 0;
    always #5 clk = ~clk;

    // Main instance, DEG = 8
    logic             in_valid = 0, in_ready;
    logic [MAG_W-1:0] in_min1 = 0, in_min2 = 0;
    logic [IDX_W-1:0] in_idx = 0;
    logic [7:0]       in_signs = 0;
    logic             out_valid, out_ready = 1, out_last, err_idx, dbg_state;
    logic [MAG_W:0]   out_msg;
    logic [IDX_W-1:0] out_edge;

    // Second instance, DEG = 6, for out-of-range index
    logic             in_valid_b = 0, in_ready_b;
    logic [MAG_W-1:0] in_min1_b = 0, in_min2_b = 0;
    logic [IDX_W-1:0] in_idx_b = 0;
    logic [5:0]       in_signs_b = 0;
    logic             out_valid_b, out_ready_b = 1, out_last_b, err_idx_b, dbg_state_b;
    logic [MAG_W:0]   out_msg_b;
    logic [IDX_W-1:0] out_edge_b;

    cn_msg_expander #(.MAG_W(MAG_W), .DEG(8), .IDX_W(IDX_W), .OFFSET(OFFSET)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_min1(in_min1), .in_min2(in_min2), .in_idx(in_idx), .in_signs(in_signs),
        .out_valid(out_valid), .out_ready(out_ready), .out_msg(out_msg),
        .out_edge(out_edge), .out_last(out_last), .err_idx(err_idx), .dbg_state(dbg_state)
    );

    cn_msg_expander #(.MAG_W(MAG_W), .DEG(6), .IDX_W(IDX_W), .OFFSET(OFFSET)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_min1(in_min1_b), .in_min2(in_min2_b), .in_idx(in_idx_b), .in_signs(in_signs_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_msg(out_msg_b),
        .out_edge(out_edge_b), .out_last(out_last_b), .err_idx(err_idx_b), .dbg_state(dbg_state_b)
    );

    int checks = 0;
    int failures = 0;
    int rec_cnt = 0;
    bit rand_rdy = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] tab[8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: magnitude from min1/min2 choice minus offset clamped at zero;
    // sign is the parity of every other edge's sign; zero is always positive.
    function automatic logic [MAG_W:0] ref_msg(input int m1, input int m2, input int idx,
                                               input logic [7:0] sg, input int e, input int deg);
        int raw, m, ones;
        logic s;
        raw = (e == idx) ? m2 : m1;
        m = raw - OFFSET;
        if (m < 0) m = 0;
        ones = 0;
        for (int k = 0; k < deg; k++)
            if (k != e && sg[k]) ones++;
        s = (m != 0) && (ones % 2 == 1);
        return {s, MAG_W'(m)};
    endfunction

    function automatic logic [W-1:0] beat(input int e, input int deg, input logic [MAG_W:0] msg);
        return {(e == deg - 1), IDX_W'(e), msg};
    endfunction

    task automatic push_rec(input logic [MAG_W-1:0] m1, input logic [MAG_W-1:0] m2,
                            input logic [IDX_W-1:0] idx, input logic [7:0] sg, input bit use_tab);
        int n = 0;
        @(negedge clk);
        in_valid = 1; in_min1 = m1; in_min2 = m2; in_idx = idx; in_signs = sg;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("push_timeout", 0, 1);
            in_valid = 0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 0;
        rec_cnt++;
        for (int e = 0; e < 8; e++)
            exp_q.push_back(use_tab ? tab[e] : beat(e, 8, ref_msg(m1, m2, idx, sg, e, 8)));
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("drain", exp_q.size(), 0);
        @(negedge clk);
    endtask

    task automatic wait_edge(input logic [IDX_W-1:0] target);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!(out_valid && out_edge == target) && n < 40);
        check("wait_edge", {out_valid, out_edge}, {1'b1, target});
    endtask

    // Scoreboard monitor for the main instance
    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready", in_ready, rec_cnt < 2);
            check("out_valid", out_valid, exp_q.size() != 0);
            if (out_valid && exp_q.size() != 0) begin
                check("beat", {out_last, out_edge, out_msg}, exp_q[0]);
                if (out_ready) begin
                    if (exp_q[0][W-1]) rec_cnt--;
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    always @(posedge clk)
        if (rand_rdy) begin
            #1;
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end

    initial begin
        logic [MAG_W:0] held_msg;
        logic [IDX_W-1:0] held_edge;
        logic [5:0] sg_b;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_msg", out_msg, 0);
        check("rst_out_edge", out_edge, 0);
        check("rst_out_last", out_last, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_err_idx", err_idx, 0);
        check("rst_err_idx_b", err_idx_b, 0);
        rst_n = 1;

        // Basic expand, fixed expected values
        tab[0] = {1'b0, 3'd0, 6'b100001}; tab[1] = {1'b0, 3'd1, 6'b000001};
        tab[2] = {1'b0, 3'd2, 6'b100001}; tab[3] = {1'b0, 3'd3, 6'b000100};
        tab[4] = {1'b0, 3'd4, 6'b000001}; tab[5] = {1'b0, 3'd5, 6'b000001};
        tab[6] = {1'b0, 3'd6, 6'b000001}; tab[7] = {1'b1, 3'd7, 6'b000001};
        out_ready = 1;
        push_rec(5'd2, 5'd5, 3'd3, 8'b00000101, 1);
        @(negedge clk);
        check("basic_latency", {out_valid, out_edge}, {1'b1, 3'd0});
        drain();

        // Zero saturation, no negative zero
        for (int e = 0; e < 8; e++) tab[e] = {(e == 7), 3'(e), 6'b000000};
        push_rec(5'd0, 5'd0, 3'd2, 8'b11111111, 1);
        drain();

        // Bad index on the DEG=6 instance
        sg_b = 6'($urandom);
        @(negedge clk);
        in_valid_b = 1; in_min1_b = 5'd3; in_min2_b = 5'd6; in_idx_b = 3'd7; in_signs_b = sg_b;
        check("b_in_ready", in_ready_b, 1);
        @(posedge clk);
        #1;
        in_valid_b = 0;
        for (int e = 0; e < 6; e++) begin
            @(negedge clk);
            check("b_beat", {out_valid_b, out_last_b, out_edge_b, out_msg_b},
                  {1'b1, beat(e, 6, ref_msg(3, 6, 7, {2'b00, sg_b}, e, 6))});
            check("b_mag", out_msg_b[MAG_W-1:0], 2);
            check("b_err", err_idx_b, 1);
        end
        repeat (3) @(negedge clk);
        check("b_idle", out_valid_b, 0);
        check("b_err_sticky", err_idx_b, 1);
        check("main_err_clear", err_idx, 0);

        // Backpressure at edge 2, then fill the buffer
        push_rec(5'($urandom), 5'($urandom), 3'($urandom), 8'($urandom), 0);
        wait_edge(3'd2);
        out_ready = 0;
        held_msg = out_msg;
        held_edge = out_edge;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_msg_hold", out_msg, held_msg);
            check("bp_edge_hold", out_edge, held_edge);
            check("bp_valid_hold", out_valid, 1);
        end
        push_rec(5'($urandom), 5'($urandom), 3'($urandom), 8'($urandom), 0);
        @(negedge clk);
        check("bp_full", in_ready, 0);
        fork
            push_rec(5'($urandom), 5'($urandom), 3'($urandom), 8'($urandom), 0);
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1;
            end
        join
        drain();

        // Back-to-back: 24 beats with no bubble
        fork
            for (int r = 0; r < 3; r++)
                push_rec(5'($urandom), 5'($urandom), 3'($urandom), 8'($urandom), 0);
            begin
                int n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!out_valid && n < 50);
                for (int i = 0; i < 24; i++) begin
                    if (i > 0) @(negedge clk);
                    check("b2b_valid", out_valid, 1);
                    check("b2b_edge_last", {out_last, out_edge}, {(i % 8 == 7), 3'(i % 8)});
                end
            end
        join
        drain();

        // Randomized records, gaps and backpressure
        rand_rdy = 1;
        for (int r = 0; r < 40; r++) begin
            repeat ($urandom_range(0, 6)) @(negedge clk);
            push_rec(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                     3'($urandom_range(0, 7)), 8'($urandom), 0);
        end
        rand_rdy = 0;
        @(posedge clk);
        #2;
        out_ready = 1;
        drain();

        // Reset mid-record with two records buffered
        push_rec(5'($urandom), 5'($urandom), 3'($urandom), 8'($urandom), 0);
        push_rec(5'($urandom), 5'($urandom), 3'($urandom), 8'($urandom), 0);
        wait_edge(3'd4);
        check("pre_rst_err_b", err_idx_b, 1);
        rst_n = 0;
        in_valid = 1;
        exp_q.delete();
        rec_cnt = 0;
        @(posedge clk);
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_err_idx", err_idx, 0);
        check("mid_rst_err_idx_b", err_idx_b, 0);
        check("mid_rst_outputs", {out_msg, out_edge, out_last}, 0);
        in_valid = 0;
        rst_n = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("no_stale", {out_valid, out_valid_b}, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=%0d", 1, 0);
        $fatal(1, "timeout");
    end

endmodule
